// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM,
// stop-bit check with one-cycle data-valid and framing-error strobes.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 217,
    parameter int CNT_W        = 16
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Busy,
    output logic       o_Frame_Err
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } rx_state_t;

    rx_state_t        r_State;
    logic             r_Sync1;
    logic             r_Sync2;
    logic [CNT_W-1:0] r_Count;
    logic [2:0]       r_BitIdx;
    logic [7:0]       r_Shift;

    logic w_RxS;
    logic w_Terminal;
    logic w_Half;

    assign w_RxS      = r_Sync2;
    assign w_Terminal = (r_Count == TERMINAL);
    assign w_Half     = (r_Count == HALF);

    // Synchroniser flops reset to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Sync1 <= 1'b1;
            r_Sync2 <= 1'b1;
        end else begin
            r_Sync1 <= i_RX_Serial;
            r_Sync2 <= r_Sync1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State     <= S_IDLE;
            r_Count     <= '0;
            r_BitIdx    <= 3'd0;
            r_Shift     <= 8'h00;
            o_RX_DV     <= 1'b0;
            o_RX_Byte   <= 8'h00;
            o_RX_Busy   <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            o_RX_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
            case (r_State)
                S_IDLE: begin
                    r_Count <= '0;
                    if (!w_RxS) begin
                        r_State   <= S_START;
                        o_RX_Busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_Half) begin
                        r_Count <= '0;
                        if (!w_RxS) begin
                            r_State  <= S_DATA;
                            r_BitIdx <= 3'd0;
                        end else begin
                            r_State   <= S_IDLE;
                            o_RX_Busy <= 1'b0;
                        end
                    end else begin
                        r_Count <= r_Count + CNT_W'(1);
                    end
                end
                // Counting from mid-start, each terminal count lands on the centre of the next bit.
                S_DATA: begin
                    if (w_Terminal) begin
                        r_Count           <= '0;
                        r_Shift[r_BitIdx] <= w_RxS;
                        if (r_BitIdx == 3'd7) begin
                            r_State <= S_STOP;
                        end else begin
                            r_BitIdx <= r_BitIdx + 3'd1;
                        end
                    end else begin
                        r_Count <= r_Count + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_Terminal) begin
                        r_Count <= '0;
                        if (w_RxS) begin
                            o_RX_Byte <= r_Shift;
                            o_RX_DV   <= 1'b1;
                            r_State   <= S_IDLE;
                            o_RX_Busy <= 1'b0;
                        end else begin
                            o_Frame_Err <= 1'b1;
                            r_State     <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_Count <= r_Count + CNT_W'(1);
                    end
                end
                // A line held low after a bad stop bit is a break, not a new start bit.
                S_WAIT_IDLE: begin
                    r_Count <= '0;
                    if (w_RxS) begin
                        r_State   <= S_IDLE;
                        o_RX_Busy <= 1'b0;
                    end
                end
                default: begin
                    r_State   <= S_IDLE;
                    r_Count   <= '0;
                    o_RX_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus random traffic,
// with a byte/frame-error queue model built from the frames the bench sends.
module tb_uart_rx_core;

    localparam int CPB     = 217;
    localparam int HALF    = (CPB - 1) / 2;
    localparam int LAT_NOM = 2 + 1 + HALF + 9 * CPB + 2;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       rxLine = 1'b1;
    logic       dv;
    logic [7:0] rxByte;
    logic       busy;
    logic       ferr;

    int          assertCount = 0;
    int          failCount   = 0;
    longint      cycle       = 0;
    longint      lastDvCycle = 0;
    longint      frameStartCycle = 0;
    int          feCount     = 0;
    int          bothCount   = 0;
    int          expFe       = 0;
    logic [7:0]  dvQ[$];
    logic [7:0]  expQ[$];

    uart_rx_core #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_RX_Serial(rxLine),
        .o_RX_DV    (dv),
        .o_RX_Byte  (rxByte),
        .o_RX_Busy  (busy),
        .o_Frame_Err(ferr)
    );

    // 40 ns clock period (25 MHz).
    always #20 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cycle++;

    // Monitor: strobes are sampled on the falling edge, so each one-cycle pulse is seen exactly once.
    always @(negedge clk) begin
        if (dv) begin
            dvQ.push_back(rxByte);
            lastDvCycle = cycle;
        end
        if (ferr) feCount++;
        if (dv && ferr) bothCount++;
    end

    // Watchdog so the run can never hang.
    initial begin
        #(40 * 100000);
        $display("[TB] FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold the line at one level for n clocks; all line changes happen on falling edges.
    task automatic sendLevel(input logic b, input int n);
        rxLine = b;
        repeat (n) @(negedge clk);
    endtask

    // Transmit one 8N1 frame and record what a correct receiver must report for it.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        frameStartCycle = cycle;
        sendLevel(1'b0, CPB);
        for (int i = 0; i < 8; i++) sendLevel(data[i], CPB);
        sendLevel(stopBit, CPB);
        if (stopBit) expQ.push_back(data);
        else expFe++;
    endtask

    // Compare everything received since the last call against the model.
    task automatic checkReceived(input string tag);
        checkOutput({tag, "_dv_count"}, 32'(dvQ.size()), 32'(expQ.size()));
        while (dvQ.size() > 0 && expQ.size() > 0)
            checkOutput({tag, "_byte"}, 32'(dvQ.pop_front()), 32'(expQ.pop_front()));
        dvQ.delete();
        expQ.delete();
        checkOutput({tag, "_frame_err_count"}, 32'(feCount), 32'(expFe));
        checkOutput({tag, "_dv_and_ferr_together"}, 32'(bothCount), 32'd0);
    endtask

    initial begin
        logic [7:0] rnd;
        logic       good;
        longint     lat;

        repeat (3) @(negedge clk);
        checkOutput("reset_dv", 32'(dv), 32'd0);
        checkOutput("reset_byte", 32'(rxByte), 32'h00);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ferr", 32'(ferr), 32'd0);
        rst = 1'b0;
        sendLevel(1'b1, 10);

        $display("[TB] single frame 8'hAA");
        applyStimulus(8'hAA, 1'b1);
        lat = lastDvCycle - frameStartCycle;
        assertCount++;
        assert (lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2) else begin
            failCount++;
            $error("[TB] FAIL latency: observed %0d expected %0d +/-2", lat, LAT_NOM);
        end
        sendLevel(1'b1, 20);
        checkReceived("single");
        checkOutput("single_busy_low", 32'(busy), 32'd0);
        checkOutput("single_byte_held", 32'(rxByte), 32'hAA);

        $display("[TB] data extremes");
        applyStimulus(8'h00, 1'b1);
        sendLevel(1'b1, 5);
        applyStimulus(8'hFF, 1'b1);
        sendLevel(1'b1, 5);
        applyStimulus(8'h3F, 1'b1);
        sendLevel(1'b1, 10);
        checkReceived("extremes");

        $display("[TB] start-bit glitch");
        sendLevel(1'b0, 20);
        checkOutput("glitch_busy_high", 32'(busy), 32'd1);
        sendLevel(1'b0, 30);
        sendLevel(1'b1, 150);
        checkOutput("glitch_busy_low", 32'(busy), 32'd0);
        checkReceived("glitch");
        checkOutput("glitch_byte_kept", 32'(rxByte), 32'h3F);

        $display("[TB] framing error and break");
        applyStimulus(8'hAA, 1'b1);
        sendLevel(1'b1, 5);
        applyStimulus(8'h55, 1'b0);
        sendLevel(1'b0, 3 * CPB - 10);
        checkOutput("break_busy_high", 32'(busy), 32'd1);
        sendLevel(1'b0, 10);
        sendLevel(1'b1, 10);
        checkOutput("break_busy_low", 32'(busy), 32'd0);
        checkOutput("break_byte_kept", 32'(rxByte), 32'hAA);
        checkReceived("framing");
        applyStimulus(8'hC3, 1'b1);
        sendLevel(1'b1, 10);
        checkReceived("after_break");

        $display("[TB] back-to-back frames");
        applyStimulus(8'h3F, 1'b1);
        applyStimulus(8'hC5, 1'b1);
        sendLevel(1'b1, 10);
        checkReceived("back_to_back");

        // Reset lands part-way through bit 4; the looped-back transmitter shares the reset, so the line idles.
        $display("[TB] reset mid-frame");
        sendLevel(1'b0, CPB);
        for (int i = 0; i < 4; i++) sendLevel(logic'(i % 2), CPB);
        sendLevel(1'b0, 100);
        #5;
        rst    = 1'b1;
        rxLine = 1'b1;
        #1;
        checkOutput("midreset_dv", 32'(dv), 32'd0);
        checkOutput("midreset_byte", 32'(rxByte), 32'h00);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_ferr", 32'(ferr), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sendLevel(1'b1, 2 * CPB);
        checkReceived("midreset");
        checkOutput("midreset_byte_after", 32'(rxByte), 32'h00);
        applyStimulus(8'h81, 1'b1);
        sendLevel(1'b1, 10);
        checkReceived("after_reset");

        $display("[TB] random traffic");
        for (int k = 0; k < 8; k++) begin
            rnd  = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            applyStimulus(rnd, good);
            sendLevel(1'b1, good ? int'($urandom_range(0, 40)) : int'($urandom_range(10, 40)));
        end
        sendLevel(1'b1, 10);
        checkReceived("random");
        checkOutput("random_busy_low", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
